// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default widths and the bubble word.
// Fetch queue, pipeir and pipeid all draw their NOP from here.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/pfq_ram.sv
// Fetch queue storage: one sync write port, one async read port.
// Contents are never cleared; validity lives in the control logic.
module pfq_ram
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W_DEF + ADDR_W_DEF,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the offered entry into its slot.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction queue between fetch and decode.
// Head is read combinationally; flush drops every entry.
module pipe_fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(NOP_WORD_DEF),
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_inst,
  input  logic [ADDR_W-1:0] enq_pc4,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_inst,
  output logic [ADDR_W-1:0] deq_pc4,
  output logic [LVL_W-1:0]  level
);

  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam int unsigned W = DATA_W + ADDR_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_enq, do_deq;
  logic [W-1:0]     rdata;

  assign enq_ready = (level_q != FULL);
  assign deq_valid = (level_q != '0);
  assign level     = level_q;

  assign do_enq = enq_valid && enq_ready && !flush;
  assign do_deq = deq_valid && deq_ready && !flush;

  pfq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clock_i (clock),
    .we_i    (do_enq),
    .waddr_i (wr_ptr_q),
    .wdata_i ({enq_inst, enq_pc4}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign deq_inst = deq_valid ? rdata[W-1:ADDR_W] : NOP_WORD;
  assign deq_pc4  = deq_valid ? rdata[ADDR_W-1:0] : '0;

  // Next pointers and occupancy; flush wins over any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case (1'b1)
      flush: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        level_d  = '0;
      end
      (do_enq && !do_deq): level_d = level_q + LVL_W'(1);
      (do_deq && !do_enq): level_d = level_q - LVL_W'(1);
      default: ;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Bench for pipe_fetch_queue at DEPTH 4, 2, 8 and 64.
// All instances share stimulus; each has its own reference queue.
module tb_pipe_fetch_queue;

  localparam int N = 4;

  function automatic int dep(int g);
    case (g)
      0:       return 4;
      1:       return 2;
      2:       return 8;
      default: return 64;
    endcase
  endfunction

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush, ev, dr;
  logic [31:0] ei, ep;

  logic        er [N];
  logic        dv [N];
  logic [31:0] di [N];
  logic [31:0] dp [N];
  logic [6:0]  lvl [N];

  int errors = 0;
  int checks = 0;

  logic [63:0] mq [N][$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = dep(g);
    logic [$clog2(D+1)-1:0] lv;
    pipe_fetch_queue #(
      .DATA_W   (32),
      .ADDR_W   (32),
      .DEPTH    (D),
      .NOP_WORD (32'h0000_0000)
    ) u_dut (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (flush),
      .enq_valid (ev),
      .enq_ready (er[g]),
      .enq_inst  (ei),
      .enq_pc4   (ep),
      .deq_valid (dv[g]),
      .deq_ready (dr),
      .deq_inst  (di[g]),
      .deq_pc4   (dp[g]),
      .level     (lv)
    );
    assign lvl[g] = 7'(lv);
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare against the reference queues, then apply
  // the handshakes that the coming edge will perform.
  always @(negedge clock) begin
    for (int g = 0; g < N; g++) begin
      int sz;
      logic [63:0] exp;
      if (!resetn) begin
        mq[g].delete();
        continue;
      end
      sz = mq[g].size();
      chk($sformatf("level[d%0d]", dep(g)),
          64'(lvl[g]), 64'(sz));
      chk($sformatf("deq_valid[d%0d]", dep(g)),
          64'(dv[g]), 64'(sz != 0));
      chk($sformatf("enq_ready[d%0d]", dep(g)),
          64'(er[g]), 64'(sz != dep(g)));
      if (sz == 0)
        chk($sformatf("empty_head[d%0d]", dep(g)),
            {di[g], dp[g]}, 64'h0);
      if (flush) begin
        mq[g].delete();
      end else begin
        if (sz != 0 && dr) begin
          exp = mq[g].pop_front();
          chk($sformatf("head[d%0d]", dep(g)),
              {di[g], dp[g]}, exp);
        end
        if (sz != dep(g) && ev)
          mq[g].push_back({ei, ep});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set(logic f, logic v, logic [31:0] i,
                     logic [31:0] p, logic r);
    flush = f; ev = v; ei = i; ep = p; dr = r;
  endtask

  initial begin
    resetn = 1'b0;
    set(0, 0, 0, 0, 0);
    repeat (2) step();
    resetn = 1'b1;
    step();
    chk("rst_dv", 64'(dv[0]), 64'd0);
    chk("rst_er", 64'(er[0]), 64'd1);
    chk("rst_lvl", 64'(lvl[0]), 64'd0);
    chk("rst_inst", 64'(di[0]), 64'd0);

    set(0, 1, 32'h2002_0005, 32'h4, 0);
    step();
    set(0, 0, 0, 0, 0);
    chk("first_dv", 64'(dv[0]), 64'd1);
    chk("first_inst", 64'(di[0]), 64'h2002_0005);
    chk("first_pc4", 64'(dp[0]), 64'h4);
    chk("first_lvl", 64'(lvl[0]), 64'd1);
    set(1, 0, 0, 0, 0);
    step();

    for (int k = 1; k <= 5; k++) begin
      set(0, 1, 32'h100 + k, 32'h4 * k, 0);
      step();
      if (k == 4) begin
        chk("full_lvl", 64'(lvl[0]), 64'd4);
        chk("full_er", 64'(er[0]), 64'd0);
      end
    end
    chk("held_lvl", 64'(lvl[0]), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      set(0, 0, 0, 0, 1);
      chk($sformatf("pop%0d", k), 64'(di[0]),
          64'(32'h100 + k));
      step();
    end
    set(1, 0, 0, 0, 0);
    step();

    for (int k = 0; k < 12; k++) begin
      set(0, 1, 32'h200 + k, 32'h20 + k, k >= 2);
      step();
      if (k >= 2)
        chk("steady_lvl", 64'(lvl[0]), 64'd2);
    end
    set(1, 0, 0, 0, 0);
    step();

    for (int k = 0; k < 3; k++) begin
      set(0, 1, 32'h300 + k, 32'h30 + k, 0);
      step();
    end
    chk("pre_flush_lvl", 64'(lvl[0]), 64'd3);
    set(1, 1, 32'hDEAD_BEEF, 32'h99, 1);
    step();
    set(0, 0, 0, 0, 0);
    chk("flush_lvl", 64'(lvl[0]), 64'd0);
    chk("flush_dv", 64'(dv[0]), 64'd0);
    chk("flush_inst", 64'(di[0]), 64'd0);

    for (int k = 0; k < 2; k++) begin
      set(0, 1, 32'h400 + k, 32'h40 + k, 0);
      step();
    end
    set(0, 0, 0, 0, 0);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_dv", 64'(dv[0]), 64'd0);
    chk("arst_er", 64'(er[0]), 64'd1);
    chk("arst_lvl", 64'(lvl[0]), 64'd0);
    chk("arst_head", {di[0], dp[0]}, 64'h0);
    @(negedge clock);
    step();
    resetn = 1'b1;
    set(0, 1, 32'hAC01_0000, 32'h8, 0);
    step();
    set(0, 0, 0, 0, 0);
    chk("post_rst_inst", 64'(di[0]), 64'hAC01_0000);
    chk("post_rst_pc4", 64'(dp[0]), 64'h8);

    for (int c = 0; c < 10000; c++) begin
      set($urandom_range(0, 40) == 0,
          $urandom_range(0, 3) != 0,
          $urandom, $urandom,
          $urandom_range(0, 2) != 0);
      step();
    end
    set(0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
